// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - bundle of fetch, data and memory port signals for imem_port_arbiter
//
// Ports (master = arbiter view):
//   fetch  : if_req, if_addr (in)  / if_gnt, if_rvalid, if_rdata, if_freeze (out)
//   data   : d_req, d_we, d_addr, d_wdata (in) / d_gnt, d_rvalid, d_rdata (out)
//   memory : mem_rdata (in) / mem_en, mem_we, mem_addr, mem_wdata (out)
// The slave modport is the requesters' and memory's view of the same wires.

interface imem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_freeze;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_freeze,
      output d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_freeze,
      input  d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - fetch/data arbiter for a single-port fixed-latency unified memory
//
// One transaction in flight at a time. Data wins over fetch unless fetch has
// already waited through MAX_WAIT consecutive data grants.
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-low reset
//   io_bus  : imem_port_arbiter_if.master (fetch port, data port, memory port)

module imem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 4
) (
   input logic                  i_clk,
   input logic                  i_rst,
   imem_port_arbiter_if.master  io_bus
);
   localparam int LW = $clog2(MEM_LAT + 1);
   localparam int SW = $clog2(MAX_WAIT + 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [LW-1:0]     r_lat_cnt;
   logic [SW-1:0]     r_starve;
   logic              r_owner_d;
   logic              r_we;
   logic              r_if_rvalid;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   logic              w_if_gnt;
   logic              w_d_gnt;
   logic              w_done;
   logic              w_starved;

   assign w_starved = io_bus.if_req && (r_starve == SW'(MAX_WAIT));

   // Grants are gated by i_rst so nothing issues while reset is held.
   always_comb begin
      w_next_state = r_state;
      w_if_gnt     = 1'b0;
      w_d_gnt      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_rst) begin
               if (io_bus.d_req && !w_starved) begin
                  w_d_gnt = 1'b1;
               end else if (io_bus.if_req) begin
                  w_if_gnt = 1'b1;
               end
               if (w_d_gnt || w_if_gnt) begin
                  w_next_state = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            // lat_cnt == 1 marks the cycle mem_rdata is valid.
            if (r_lat_cnt == LW'(1)) begin
               w_done       = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      io_bus.mem_en    = 1'b0;
      io_bus.mem_we    = 1'b0;
      io_bus.mem_addr  = '0;
      io_bus.mem_wdata = '0;
      if (w_d_gnt) begin
         io_bus.mem_en    = 1'b1;
         io_bus.mem_we    = io_bus.d_we;
         io_bus.mem_addr  = io_bus.d_addr;
         io_bus.mem_wdata = io_bus.d_wdata;
      end else if (w_if_gnt) begin
         io_bus.mem_en    = 1'b1;
         io_bus.mem_addr  = io_bus.if_addr;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_lat_cnt   <= '0;
         r_owner_d   <= 1'b0;
         r_we        <= 1'b0;
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         if (w_if_gnt || w_d_gnt) begin
            r_owner_d <= w_d_gnt;
            r_we      <= w_d_gnt && io_bus.d_we;
            r_lat_cnt <= LW'(MEM_LAT);
         end else if (r_state == S_BUSY) begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
         end
         if (w_done) begin
            if (r_owner_d) begin
               r_d_rvalid <= 1'b1;
               r_d_rdata  <= r_we ? '0 : io_bus.mem_rdata;
            end else begin
               r_if_rvalid <= 1'b1;
               r_if_rdata  <= io_bus.mem_rdata;
            end
         end
      end
   end

   // Counts data grants that overtook a waiting fetch.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_starve <= '0;
      end else if (!io_bus.if_req || w_if_gnt) begin
         r_starve <= '0;
      end else if (w_d_gnt && (r_starve != SW'(MAX_WAIT))) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   assign io_bus.if_gnt    = w_if_gnt;
   assign io_bus.d_gnt     = w_d_gnt;
   assign io_bus.if_rvalid = r_if_rvalid;
   assign io_bus.if_rdata  = r_if_rdata;
   assign io_bus.d_rvalid  = r_d_rvalid;
   assign io_bus.d_rdata   = r_d_rdata;
   assign io_bus.if_freeze = io_bus.if_req & ~r_if_rvalid;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - randomized scoreboard bench for imem_port_arbiter

module tb_imem_port_arbiter;
   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int MEM_LAT  = 2;
   localparam int MAX_WAIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   imem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus.master)
   );

   typedef struct packed {
      int          cyc;
      logic        is_d;
      logic        we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } iss_t;

   typedef struct packed {
      int          cyc;
      logic [DW-1:0] data;
   } cmp_t;

   iss_t exp_iss_q[$];
   cmp_t exp_if_q[$];
   cmp_t exp_d_q[$];
   cmp_t mem_pend_q[$];

   logic [DW-1:0] ref_mem[64];
   logic [DW-1:0] mem_arr[64];

   int   cyc     = 0;
   int   checks  = 0;
   int   errors  = 0;
   int   free_at = 0;
   int   starve  = 0;
   logic g_if    = 1'b0;
   logic g_d     = 1'b0;
   int   p_if    = 0;
   int   p_d     = 0;
   int   p_we    = 0;
   logic [DW-1:0] m_if_rdata = '0;
   logic [DW-1:0] m_d_rdata  = '0;

   int ph_if[6] = '{100, 100,   0, 60, 25, 90};
   int ph_d [6] = '{100,   0, 100, 60, 25, 90};
   int ph_we[6] = '{  0,   0,  50, 30, 50, 40};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   // Requesters: hold a request until it is granted, then maybe issue a new one.
   task automatic drive_reqs();
      if (!bus.if_req || g_if) begin
         if ($urandom_range(0, 99) < p_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = AW'($urandom_range(0, 63) * 4);
         end else begin
            bus.if_req  = 1'b0;
            bus.if_addr = $urandom;
         end
      end
      if (!bus.d_req || g_d) begin
         if ($urandom_range(0, 99) < p_d) begin
            bus.d_req   = 1'b1;
            bus.d_addr  = AW'($urandom_range(0, 63) * 4);
            bus.d_we    = ($urandom_range(0, 99) < p_we);
            bus.d_wdata = $urandom;
         end else begin
            bus.d_req   = 1'b0;
            bus.d_we    = 1'b0;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
         end
      end
   endtask

   // Reference model: the port is free again MEM_LAT+1 cycles after an issue;
   // completions are scheduled by absolute cycle number.
   task automatic model_step();
      int idx;
      if (!rst) begin
         exp_iss_q.delete();
         exp_if_q.delete();
         exp_d_q.delete();
         free_at = 0;
         starve  = 0;
         g_if    = 1'b0;
         g_d     = 1'b0;
      end else begin
         g_d  = (cyc >= free_at) && bus.d_req && !(bus.if_req && starve == MAX_WAIT);
         g_if = (cyc >= free_at) && !g_d && bus.if_req;
         if (g_d) begin
            idx = int'(bus.d_addr[7:2]);
            exp_iss_q.push_back('{cyc, 1'b1, bus.d_we, bus.d_addr, bus.d_wdata});
            if (bus.d_we) begin
               ref_mem[idx] = bus.d_wdata;
               exp_d_q.push_back('{cyc + MEM_LAT + 1, DW'(0)});
            end else begin
               exp_d_q.push_back('{cyc + MEM_LAT + 1, ref_mem[idx]});
            end
            free_at = cyc + MEM_LAT + 1;
         end else if (g_if) begin
            idx = int'(bus.if_addr[7:2]);
            exp_iss_q.push_back('{cyc, 1'b0, 1'b0, bus.if_addr, DW'(0)});
            exp_if_q.push_back('{cyc + MEM_LAT + 1, ref_mem[idx]});
            free_at = cyc + MEM_LAT + 1;
         end
         if (!bus.if_req || g_if) starve = 0;
         else if (g_d) starve = (starve < MAX_WAIT) ? starve + 1 : MAX_WAIT;
      end
   endtask

   task automatic cycle_step(input logic rst_val);
      @(posedge clk);
      cyc++;
      #1;
      rst = rst_val;
      if (rst_val) drive_reqs();
      #2;
      model_step();
   endtask

   // Memory: reads sampled at issue, data presented MEM_LAT cycles later, junk otherwise.
   initial begin : mem_resp
      int   idx;
      cmp_t e;
      forever begin
         @(negedge clk);
         if (bus.mem_en) begin
            idx = int'(bus.mem_addr[7:2]);
            if (bus.mem_we) mem_arr[idx] = bus.mem_wdata;
            else mem_pend_q.push_back('{cyc + MEM_LAT, mem_arr[idx]});
         end
         @(posedge clk);
         #1;
         while (mem_pend_q.size() > 0 && mem_pend_q[0].cyc < cyc) void'(mem_pend_q.pop_front());
         if (mem_pend_q.size() > 0 && mem_pend_q[0].cyc == cyc) begin
            e = mem_pend_q.pop_front();
            bus.mem_rdata = e.data;
         end else begin
            bus.mem_rdata = $urandom;
         end
      end
   end

   // Monitor: compares DUT outputs against the scoreboard queues.
   initial begin : monitor
      logic        e_iss, e_if, e_d;
      logic [67:0] exp_vec;
      iss_t        ei;
      cmp_t        ec;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("reset_out", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                              bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata}, '0);
            m_if_rdata = '0;
            m_d_rdata  = '0;
         end else begin
            e_iss = (exp_iss_q.size() > 0) && (exp_iss_q[0].cyc == cyc);
            exp_vec = '0;
            if (e_iss) begin
               ei = exp_iss_q.pop_front();
               exp_vec = {!ei.is_d, ei.is_d, 1'b1, ei.we, ei.addr, ei.wdata};
            end
            chk("issue", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                          bus.mem_addr, bus.mem_wdata}, exp_vec);

            e_if = (exp_if_q.size() > 0) && (exp_if_q[0].cyc == cyc);
            if (e_if) begin
               ec = exp_if_q.pop_front();
               m_if_rdata = ec.data;
            end
            chk("if_rvalid", bus.if_rvalid, e_if);
            chk("if_rdata", bus.if_rdata, m_if_rdata);
            chk("if_freeze", bus.if_freeze, bus.if_req & ~e_if);

            e_d = (exp_d_q.size() > 0) && (exp_d_q[0].cyc == cyc);
            if (e_d) begin
               ec = exp_d_q.pop_front();
               m_d_rdata = ec.data;
            end
            chk("d_rvalid", bus.d_rvalid, e_d);
            chk("d_rdata", bus.d_rdata, m_d_rdata);
         end
      end
   end

   initial begin : stim
      bit did_rst;
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = $urandom;
         mem_arr[i] = ref_mem[i];
      end
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.d_req     = 1'b0;
      bus.d_we      = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
      repeat (3) cycle_step(1'b0);

      for (int k = 0; k < 6; k++) begin
         p_if = ph_if[k];
         p_d  = ph_d[k];
         p_we = ph_we[k];
         did_rst = 1'b0;
         for (int n = 0; n < 500; n++) begin
            // Pull reset while a transaction is still outstanding.
            if (!did_rst && n >= 200 && free_at > cyc + 1) begin
               cycle_step(1'b0);
               cycle_step(1'b0);
               did_rst = 1'b1;
            end else begin
               cycle_step(1'b1);
            end
         end
      end

      p_if = 0;
      p_d  = 0;
      repeat (12) cycle_step(1'b1);
      chk("drain", 128'(exp_iss_q.size() + exp_if_q.size() + exp_d_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates a single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes), with one transaction in flight at a time. It drives the memory port, returns registered read data to the winning requester, and generates `if_freeze` so the fetch-stage PC holds while a fetch is outstanding. The data port has priority over fetch, and a starvation counter bounds fetch wait.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 2, cycles from issue to valid `mem_rdata`; legal range ≥1
- `MAX_WAIT`, 4, maximum consecutive data grants while `if_req` is pending; legal range ≥1

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch issued this cycle
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` updated
- `if_rdata`  out  DATA_W  registered instruction word
- `if_freeze`  out  1  `if_req & ~if_rvalid`
- `d_req`  in  1  data request; held with address, `d_we` and `d_wdata` until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  write data
- `d_gnt`  out  1  data issued this cycle
- `d_rvalid`  out  1  one-cycle pulse: completion (read data or write ack)
- `d_rdata`  out  DATA_W  registered read data; 0 after a write
- `mem_en`  out  1  issue strobe to memory
- `mem_we`  out  1  write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

## Operation
- FSM states:
  - IDLE: no transaction outstanding; grants are allowed.
  - BUSY: one transaction outstanding.
- Grant, combinational, IDLE only:
  - If `d_req` and NOT (`if_req` and `starve == MAX_WAIT`): grant data.
  - Else if `if_req`: grant fetch.
  - At most one of `if_gnt`/`d_gnt` is high in any cycle.
- Issue cycle:
  - `mem_en = if_gnt | d_gnt`.
  - `mem_addr`, `mem_we`, `mem_wdata` are muxed from the winner.
  - Fetch issues always have `mem_we = 0`.
  - While not issuing, `mem_en = mem_we = 0` and `mem_addr`/`mem_wdata` = 0.
- On grant:
  - Latch owner (IF/D) and `d_we`.
  - Load `lat_cnt = MEM_LAT`; go to BUSY.
- BUSY:
  - Decrement `lat_cnt` each cycle.
  - When `lat_cnt` reaches 1 (the cycle `mem_rdata` is valid), register `mem_rdata` into the owner's rdata register on the clock edge. A write loads `d_rdata` with 0.
  - That same edge sets the owner's rvalid for the next cycle and returns to IDLE.
- Starvation counter `starve` (0..MAX_WAIT):
  - +1 on each `d_gnt` while `if_req` = 1, saturating at MAX_WAIT.
  - Cleared on `if_gnt`, or on any cycle with `if_req` = 0.
- Rdata registers hold their value until the owner's next completion.
- Other port's rvalid and rdata are unaffected by a completion.

## Timing
- Reset (async, `rst` = 0):
  - FSM → IDLE; `lat_cnt`, `starve`, owner cleared.
  - `if_rvalid`, `d_rvalid`, `if_rdata`, `d_rdata` = 0.
  - Combinational outputs follow: `if_gnt` = `d_gnt` = `mem_en` = `mem_we` = 0 while in reset.
  - An in-flight transaction is abandoned; no rvalid is ever produced for it.
- Latency:
  - Issue in cycle T → rvalid high in cycle T+MEM_LAT+1 for exactly one cycle.
  - Earliest next grant is cycle T+MEM_LAT+1 (IDLE), so a completion and a new grant may coincide.
  - Throughput is one transaction per MEM_LAT+1 cycles.
- A requester that sees its rvalid and keeps req high is treated as a new request in that same cycle.
- `if_freeze` is high in every cycle of a pending fetch except the cycle `if_rvalid` is high.
- Requests arriving during BUSY wait, and are arbitrated at the first IDLE cycle.
- Simultaneous `if_req` and `d_req` with `starve < MAX_WAIT` → data wins; `starve` increments.

## Test plan
- Reset: assert `rst` = 0 mid-BUSY. Required:
  - All registered outputs read 0.
  - No rvalid after release.
  - The next `if_req` is granted in the first cycle after `rst` = 1.
- Lone fetch (MEM_LAT = 2): `if_req` = 1, `if_addr` = 0x10 in cycle 1; memory returns 0xE3A00001. Required:
  - `if_gnt`, `mem_en` and `mem_addr` = 0x10 in cycle 1.
  - `if_rvalid` = 1 and `if_rdata` = 0xE3A00001 in cycle 4.
  - `if_freeze` = 1 in cycles 1–3, and 0 in cycle 4.
- Collision: `if_req` and `d_req` (read, `d_addr` = 0x100) both asserted in cycle 1. Required:
  - `d_gnt` in cycle 1; `d_rvalid` in cycle 4.
  - `if_gnt` in cycle 4; `if_rvalid` in cycle 7.
- Starvation (MAX_WAIT = 4): `d_req` and `if_req` held high continuously. Required:
  - Four `d_gnt` issues, then `if_gnt`, then data again.
  - The pattern D,D,D,D,I repeats.
- Write: `d_we` = 1, `d_addr` = 0x20, `d_wdata` = 0xDEADBEEF. Required:
  - Issue cycle shows `mem_we` = 1, `mem_addr` = 0x20, `mem_wdata` = 0xDEADBEEF.
  - `d_rvalid` pulses MEM_LAT+1 cycles later with `d_rdata` = 0.
  - `if_rdata` is unchanged.
- Back-to-back fetch: `if_req` held high with addresses 0x0, 0x4, 0x8. Required:
  - Grants in cycles 1, 4 and 7.
  - Each `if_rvalid` coincides with the next `if_gnt`.
